// File: rtl/core_bus_arb_pkg.sv
// Shared types and default address map for the core_bus_arb two-host / two-device arbiter.
// Consumers import this package with import core_bus_arb_pkg::*.
package core_bus_arb_pkg;

    typedef enum logic [1:0] {
        DevMem  = 2'd0,
        DevDbg  = 2'd1,
        DevNone = 2'd2
    } dev_sel_e;

    typedef enum logic {
        HostInstr = 1'b0,
        HostData  = 1'b1
    } host_sel_e;

    localparam logic [31:0] DefMemStart = 32'h0000_0000;
    localparam logic [31:0] DefMemMask  = 32'h0000_FFFF;
    localparam logic [31:0] DefDbgStart = 32'h1000_0000;
    localparam logic [31:0] DefDbgMask  = 32'h0000_0FFF;

    // True when addr falls inside the window described by base/offset-mask.
    function automatic logic addr_match(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] mask
    );
        return (addr & ~mask) == base;
    endfunction

endpackage

// File: rtl/core_bus_decode.sv
// Combinational address decoder for core_bus_arb: maps an address to SRAM, debug module or unmapped.
// SRAM takes precedence when both windows match.
module core_bus_decode
    import core_bus_arb_pkg::*;
#(
    parameter logic [31:0] MemStart = DefMemStart,
    parameter logic [31:0] MemMask  = DefMemMask,
    parameter logic [31:0] DbgStart = DefDbgStart,
    parameter logic [31:0] DbgMask  = DefDbgMask
) (
    input  logic [31:0] addr_i,
    output dev_sel_e    dev_sel_o
);

    always_comb begin
        dev_sel_o = DevNone;
        if (addr_match(addr_i, MemStart, MemMask)) begin
            dev_sel_o = DevMem;
        end else if (addr_match(addr_i, DbgStart, DbgMask)) begin
            dev_sel_o = DevDbg;
        end
    end

endmodule

// File: rtl/core_bus_arb.sv
// Ibex instr/data to SRAM/debug-module bus arbiter with one-cycle response steering.
// Define CORE_BUS_ARB_RR_EN for round-robin arbitration; otherwise instruction has fixed priority.
module core_bus_arb
    import core_bus_arb_pkg::*;
#(
    parameter logic [31:0] MemStart = DefMemStart,
    parameter logic [31:0] MemMask  = DefMemMask,
    parameter logic [31:0] DbgStart = DefDbgStart,
    parameter logic [31:0] DbgMask  = DefDbgMask
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,

    output logic        mem_req_o,
    output logic        dbg_req_o,
    output logic        dev_we_o,
    output logic [3:0]  dev_be_o,
    output logic [31:0] dev_addr_o,
    output logic [31:0] dev_wdata_o,

    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        dbg_rvalid_i,
    input  logic [31:0] dbg_rdata_i
);

    logic        instr_win;
    logic        data_win;
    logic        any_win;
    logic [31:0] win_addr;
    dev_sel_e    win_dev;

    logic        rsp_vld_q;
    host_sel_e   rsp_host_q;
    dev_sel_e    rsp_dev_q;

    logic [31:0] rsp_rdata;
    logic        rsp_err;

`ifdef CORE_BUS_ARB_RR_EN
    host_sel_e last_q;

    // On contention the host that did not win last time goes first.
    always_comb begin
        instr_win = 1'b0;
        data_win  = 1'b0;
        if (instr_req_i && data_req_i) begin
            instr_win = (last_q == HostData);
            data_win  = (last_q == HostInstr);
        end else begin
            instr_win = instr_req_i;
            data_win  = data_req_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= HostData;
        end else if (instr_win) begin
            last_q <= HostInstr;
        end else if (data_win) begin
            last_q <= HostData;
        end
    end
`else
    always_comb begin
        instr_win = instr_req_i;
        data_win  = data_req_i && !instr_req_i;
    end
`endif

    assign any_win     = instr_win || data_win;
    assign instr_gnt_o = instr_win;
    assign data_gnt_o  = data_win;

    always_comb begin
        win_addr = 32'h0;
        if (instr_win) begin
            win_addr = instr_addr_i;
        end else if (data_win) begin
            win_addr = data_addr_i;
        end
    end

    core_bus_decode #(
        .MemStart (MemStart),
        .MemMask  (MemMask),
        .DbgStart (DbgStart),
        .DbgMask  (DbgMask)
    ) u_decode (
        .addr_i    (win_addr),
        .dev_sel_o (win_dev)
    );

    // Instruction fetches are always full-word reads.
    always_comb begin
        dev_we_o    = 1'b0;
        dev_be_o    = 4'h0;
        dev_addr_o  = 32'h0;
        dev_wdata_o = 32'h0;
        if (instr_win) begin
            dev_be_o   = 4'hF;
            dev_addr_o = instr_addr_i;
        end else if (data_win) begin
            dev_we_o    = data_we_i;
            dev_be_o    = data_be_i;
            dev_addr_o  = data_addr_i;
            dev_wdata_o = data_wdata_i;
        end
    end

    assign mem_req_o = any_win && (win_dev == DevMem);
    assign dbg_req_o = any_win && (win_dev == DevDbg);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_q  <= 1'b0;
            rsp_host_q <= HostInstr;
            rsp_dev_q  <= DevNone;
        end else begin
            rsp_vld_q <= any_win;
            if (any_win) begin
                rsp_host_q <= instr_win ? HostInstr : HostData;
                rsp_dev_q  <= win_dev;
            end
        end
    end

    // Routing follows the tracking registers only; device rvalid is not trusted here.
    always_comb begin
        rsp_rdata = 32'h0;
        rsp_err   = 1'b0;
        case (rsp_dev_q)
            DevMem:  rsp_rdata = mem_rdata_i;
            DevDbg:  rsp_rdata = dbg_rdata_i;
            default: rsp_err   = 1'b1;
        endcase
    end

    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_rdata_o  = 32'h0;
        instr_err_o    = 1'b0;
        data_rvalid_o  = 1'b0;
        data_rdata_o   = 32'h0;
        data_err_o     = 1'b0;
        if (rsp_vld_q) begin
            if (rsp_host_q == HostInstr) begin
                instr_rvalid_o = 1'b1;
                instr_rdata_o  = rsp_rdata;
                instr_err_o    = rsp_err;
            end else begin
                data_rvalid_o = 1'b1;
                data_rdata_o  = rsp_rdata;
                data_err_o    = rsp_err;
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem_rvalid_i && !(rsp_vld_q && rsp_dev_q == DevMem)));
            assert (!(dbg_rvalid_i && !(rsp_vld_q && rsp_dev_q == DevDbg)));
            assert (!(instr_gnt_o && data_gnt_o));
        end
    end
`endif

endmodule

// File: tb/tb_core_bus_arb.sv
// Directed self-checking bench for core_bus_arb; honours CORE_BUS_ARB_RR_EN when defined.
// Devices are modelled as single-cycle responders driven from the bench.
module tb_core_bus_arb;

    logic        clk_i;
    logic        rst_ni;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_gnt_o;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        data_err_o;
    logic        mem_req_o;
    logic        dbg_req_o;
    logic        dev_we_o;
    logic [3:0]  dev_be_o;
    logic [31:0] dev_addr_o;
    logic [31:0] dev_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        dbg_rvalid_i;
    logic [31:0] dbg_rdata_i;

    int errors = 0;
    int checks = 0;

    logic        addr_mode;
    logic [31:0] mem_resp_val;
    logic [31:0] dbg_resp_val;

    core_bus_arb dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .dbg_req_o      (dbg_req_o),
        .dev_we_o       (dev_we_o),
        .dev_be_o       (dev_be_o),
        .dev_addr_o     (dev_addr_o),
        .dev_wdata_o    (dev_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .dbg_rvalid_i   (dbg_rvalid_i),
        .dbg_rdata_i    (dbg_rdata_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Single-cycle devices: respond the cycle after their select.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_rvalid_i <= 1'b0;
            mem_rdata_i  <= 32'h0;
            dbg_rvalid_i <= 1'b0;
            dbg_rdata_i  <= 32'h0;
        end else begin
            mem_rvalid_i <= mem_req_o;
            mem_rdata_i  <= addr_mode ? {16'hC0DE, dev_addr_o[15:0]} : mem_resp_val;
            dbg_rvalid_i <= dbg_req_o;
            dbg_rdata_i  <= dbg_resp_val;
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        checks++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rvalid: got instr=%b data=%b want 0 0", instr_rvalid_o, data_rvalid_o);
        end
        checks++;
        if (instr_rdata_o !== 32'h0 || data_rdata_o !== 32'h0 || instr_err_o !== 1'b0 || data_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_rdata_err: got %h %h %b %b want 0", instr_rdata_o, data_rdata_o, instr_err_o, data_err_o);
        end
        checks++;
        if (instr_gnt_o !== 1'b0 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b0 || dbg_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt_req: got %b %b %b %b want 0", instr_gnt_o, data_gnt_o, mem_req_o, dbg_req_o);
        end
        checks++;
        if (dev_addr_o !== 32'h0 || dev_be_o !== 4'h0 || dev_we_o !== 1'b0 || dev_wdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_dev: got addr=%h be=%h we=%b wdata=%h want 0", dev_addr_o, dev_be_o, dev_we_o, dev_wdata_o);
        end
        $display("reset: outputs sampled during reset");
        next_cycle();
        rst_ni = 1'b1;
        next_cycle();
    endtask

    task automatic test_instr_read();
        addr_mode    = 1'b0;
        mem_resp_val = 32'hDEAD_BEEF;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0080;
        @(negedge clk_i);
        checks++;
        if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL instr_rd_gnt: got instr=%b data=%b want 1 0", instr_gnt_o, data_gnt_o);
        end
        checks++;
        if (mem_req_o !== 1'b1 || dbg_req_o !== 1'b0) begin
            errors++;
            $display("FAIL instr_rd_sel: got mem=%b dbg=%b want 1 0", mem_req_o, dbg_req_o);
        end
        checks++;
        if (dev_addr_o !== 32'h0000_0080 || dev_be_o !== 4'hF || dev_we_o !== 1'b0) begin
            errors++;
            $display("FAIL instr_rd_dev: got addr=%h be=%h we=%b want 00000080 f 0", dev_addr_o, dev_be_o, dev_we_o);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        checks++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hDEAD_BEEF || instr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL instr_rd_rsp: got rvalid=%b rdata=%h err=%b want 1 deadbeef 0", instr_rvalid_o, instr_rdata_o, instr_err_o);
        end
        checks++;
        if (data_rvalid_o !== 1'b0 || instr_gnt_o !== 1'b0) begin
            errors++;
            $display("FAIL instr_rd_quiet: got data_rvalid=%b instr_gnt=%b want 0 0", data_rvalid_o, instr_gnt_o);
        end
        $display("instr rd addr=00000080 rdata=%h err=%b", instr_rdata_o, instr_err_o);
        next_cycle();
    endtask

    task automatic test_data_write();
        dbg_resp_val = 32'h0BAD_F00D;
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'b0011;
        data_addr_i  = 32'h1000_0100;
        data_wdata_i = 32'h1234_5678;
        @(negedge clk_i);
        checks++;
        if (data_gnt_o !== 1'b1 || dbg_req_o !== 1'b1 || mem_req_o !== 1'b0) begin
            errors++;
            $display("FAIL data_wr_sel: got gnt=%b dbg=%b mem=%b want 1 1 0", data_gnt_o, dbg_req_o, mem_req_o);
        end
        checks++;
        if (dev_we_o !== 1'b1 || dev_be_o !== 4'b0011 || dev_addr_o !== 32'h1000_0100 || dev_wdata_o !== 32'h1234_5678) begin
            errors++;
            $display("FAIL data_wr_dev: got we=%b be=%b addr=%h wdata=%h want 1 0011 10000100 12345678", dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        checks++;
        if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b0 || data_rdata_o !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL data_wr_rsp: got rvalid=%b err=%b rdata=%h want 1 0 0badf00d", data_rvalid_o, data_err_o, data_rdata_o);
        end
        checks++;
        if (instr_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL data_wr_other: got instr_rvalid=%b want 0", instr_rvalid_o);
        end
        $display("data wr addr=10000100 wdata=12345678 be=0011 err=%b", data_err_o);
        next_cycle();
    endtask

    task automatic test_unmapped();
        data_req_i  = 1'b1;
        data_addr_i = 32'h2000_0000;
        @(negedge clk_i);
        checks++;
        if (data_gnt_o !== 1'b1 || mem_req_o !== 1'b0 || dbg_req_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_sel: got gnt=%b mem=%b dbg=%b want 1 0 0", data_gnt_o, mem_req_o, dbg_req_o);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk_i);
        checks++;
        if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0) begin
            errors++;
            $display("FAIL unmapped_rsp: got rvalid=%b err=%b rdata=%h want 1 1 0", data_rvalid_o, data_err_o, data_rdata_o);
        end
        $display("data rd addr=20000000 err=%b rdata=%h", data_err_o, data_rdata_o);
        next_cycle();
    endtask

    task automatic test_decode_boundary();
        logic [31:0] addrs [6];
        logic [1:0]  sel   [6];   // 0 mem, 1 dbg, 2 none
        logic        prev_err;
        addrs[0] = 32'h0000_FFFC; sel[0] = 2'd0;
        addrs[1] = 32'h0001_0000; sel[1] = 2'd2;
        addrs[2] = 32'h1000_0FFC; sel[2] = 2'd1;
        addrs[3] = 32'h1000_1000; sel[3] = 2'd2;
        addrs[4] = 32'h0FFF_FFFF; sel[4] = 2'd2;
        addrs[5] = 32'h1000_0000; sel[5] = 2'd1;
        prev_err = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k < 6) begin
                data_req_i  = 1'b1;
                data_addr_i = addrs[k];
            end else begin
                idle_inputs();
            end
            @(negedge clk_i);
            if (k < 6) begin
                checks++;
                if (mem_req_o !== (sel[k] == 2'd0) || dbg_req_o !== (sel[k] == 2'd1)) begin
                    errors++;
                    $display("FAIL decode_sel[%0d]: addr=%h got mem=%b dbg=%b want %b %b", k, addrs[k], mem_req_o, dbg_req_o, sel[k] == 2'd0, sel[k] == 2'd1);
                end
            end
            if (k > 0) begin
                checks++;
                if (data_rvalid_o !== 1'b1 || data_err_o !== prev_err) begin
                    errors++;
                    $display("FAIL decode_err[%0d]: got rvalid=%b err=%b want 1 %b", k - 1, data_rvalid_o, data_err_o, prev_err);
                end
                $display("decode addr=%h err=%b", addrs[k - 1], data_err_o);
            end
            if (k < 6) prev_err = (sel[k] == 2'd2);
            next_cycle();
        end
    endtask

    task automatic test_contention();
        logic exp_ig, exp_dg, prev_ig, prev_dg;
        rst_ni = 1'b0;
        next_cycle();
        rst_ni    = 1'b1;
        addr_mode = 1'b1;
        prev_ig   = 1'b0;
        prev_dg   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            instr_req_i  = (k < 4);
            instr_addr_i = 32'h0000_0100;
            data_req_i   = (k < 4);
            data_addr_i  = 32'h0000_0200;
`ifdef CORE_BUS_ARB_RR_EN
            exp_ig = (k < 4) && (k % 2 == 0);
`else
            exp_ig = (k < 4);
`endif
            exp_dg = (k < 4) && !exp_ig;
            @(negedge clk_i);
            checks++;
            if (instr_gnt_o !== exp_ig || data_gnt_o !== exp_dg) begin
                errors++;
                $display("FAIL contend_gnt[%0d]: got instr=%b data=%b want %b %b", k, instr_gnt_o, data_gnt_o, exp_ig, exp_dg);
            end
            checks++;
            if (instr_rvalid_o !== prev_ig || data_rvalid_o !== prev_dg
                || instr_rdata_o !== (prev_ig ? 32'hC0DE_0100 : 32'h0)
                || data_rdata_o !== (prev_dg ? 32'hC0DE_0200 : 32'h0)) begin
                errors++;
                $display("FAIL contend_rsp[%0d]: got irv=%b ird=%h drv=%b drd=%h want %b %b", k, instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o, prev_ig, prev_dg);
            end
            $display("contend cycle %0d: instr_gnt=%b data_gnt=%b", k, instr_gnt_o, data_gnt_o);
            prev_ig = exp_ig;
            prev_dg = exp_dg;
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic        exp_irv [4];
        logic        exp_drv [4];
        logic [31:0] exp_ird [4];
        logic [31:0] exp_drd [4];
        addr_mode    = 1'b1;
        dbg_resp_val = 32'h5151_A0A0;
        exp_irv[0] = 0; exp_drv[0] = 0; exp_ird[0] = 32'h0;          exp_drd[0] = 32'h0;
        exp_irv[1] = 1; exp_drv[1] = 0; exp_ird[1] = 32'hC0DE_0010;  exp_drd[1] = 32'h0;
        exp_irv[2] = 0; exp_drv[2] = 1; exp_ird[2] = 32'h0;          exp_drd[2] = 32'h5151_A0A0;
        exp_irv[3] = 1; exp_drv[3] = 0; exp_ird[3] = 32'hC0DE_0020;  exp_drd[3] = 32'h0;
        for (int k = 0; k < 4; k++) begin
            idle_inputs();
            if (k == 0) begin
                instr_req_i  = 1'b1;
                instr_addr_i = 32'h0000_0010;
            end else if (k == 1) begin
                data_req_i  = 1'b1;
                data_addr_i = 32'h1000_0004;
            end else if (k == 2) begin
                instr_req_i  = 1'b1;
                instr_addr_i = 32'h0000_0020;
            end
            @(negedge clk_i);
            checks++;
            if (instr_rvalid_o !== exp_irv[k] || data_rvalid_o !== exp_drv[k]
                || instr_rdata_o !== exp_ird[k] || data_rdata_o !== exp_drd[k]) begin
                errors++;
                $display("FAIL b2b_rsp[%0d]: got irv=%b ird=%h drv=%b drd=%h want %b %h %b %h", k, instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o, exp_irv[k], exp_ird[k], exp_drv[k], exp_drd[k]);
            end
            checks++;
            if (instr_rvalid_o === 1'b1 && data_rvalid_o === 1'b1) begin
                errors++;
                $display("FAIL b2b_both[%0d]: got both rvalid high want at most one", k);
            end
            $display("b2b cycle %0d: irv=%b ird=%h drv=%b drd=%h", k, instr_rvalid_o, instr_rdata_o, data_rvalid_o, data_rdata_o);
            next_cycle();
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        addr_mode    = 1'b0;
        mem_resp_val = 32'h7777_0001;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0000_0040;
        @(negedge clk_i);
        checks++;
        if (instr_gnt_o !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_gnt: got %b want 1", instr_gnt_o);
        end
        next_cycle();
        idle_inputs();
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0 || instr_err_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_during: got irv=%b drv=%b ird=%h ierr=%b want 0", instr_rvalid_o, data_rvalid_o, instr_rdata_o, instr_err_o);
        end
        next_cycle();
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after[%0d]: got irv=%b drv=%b want 0 0", k, instr_rvalid_o, data_rvalid_o);
            end
            next_cycle();
        end
        $display("reset mid-transaction: pending response dropped");
    endtask

    initial begin
        rst_ni       = 1'b0;
        addr_mode    = 1'b0;
        mem_resp_val = 32'h0;
        dbg_resp_val = 32'h0;
        idle_inputs();
        test_reset();
        test_instr_read();
        test_data_write();
        test_unmapped();
        test_decode_boundary();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_bus_arb.md
# core_bus_arb

Two-host, two-device bus arbiter between the Ibex instruction/data ports and the SRAM and debug-module device ports. Decodes each request to SRAM, debug module or unmapped, grants one host per cycle, and steers each single-cycle-latency response back to the host that issued it. Unmapped accesses get a bus error response. Sits directly downstream of `ibex_core` and upstream of `ram_1p` and `rv_dm` in the FPGA top levels.

## Interface
- `MemStart`, 32'h0000_0000: SRAM base address.
- `MemMask`, 32'h0000_FFFF: SRAM offset mask (64 kB).
- `DbgStart`, 32'h1000_0000: debug-module base address.
- `DbgMask`, 32'h0000_0FFF: debug-module offset mask.

Ports:
- `clk_i` in 1: system clock. All logic is in this single clock domain.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `instr_req_i` in 1, `instr_addr_i` in 32: instruction request and address.
- `instr_gnt_o` out 1, `instr_rvalid_o` out 1, `instr_rdata_o` out 32, `instr_err_o` out 1: instruction grant and response.
- `data_req_i` in 1, `data_we_i` in 1, `data_be_i` in 4, `data_addr_i` in 32, `data_wdata_i` in 32: data request.
- `data_gnt_o` out 1, `data_rvalid_o` out 1, `data_rdata_o` out 32, `data_err_o` out 1: data grant and response.
- `mem_req_o` out 1, `dbg_req_o` out 1: device selects.
- `dev_we_o` out 1, `dev_be_o` out 4, `dev_addr_o` out 32, `dev_wdata_o` out 32: request lines shared by both devices.
- `mem_rvalid_i` in 1, `mem_rdata_i` in 32: SRAM response.
- `dbg_rvalid_i` in 1, `dbg_rdata_i` in 32: debug-module response.

## Operation
- **Decode:**
  - `(addr & ~MemMask) == MemStart` selects SRAM.
  - Otherwise `(addr & ~DbgMask) == DbgStart` selects the debug module.
  - Otherwise the access is unmapped. SRAM match wins if both match.
- **Arbitration:** combinational, among hosts with `req` high.
  - Default: instruction has fixed priority.
  - The winner gets `gnt=1` in the same cycle. The loser sees `gnt=0` and must hold its request.
- **Device drive:**
  - Winner's fields drive `dev_*`.
  - `mem_req_o` or `dbg_req_o` is high only for a mapped winner.
  - For instruction accesses, `dev_we_o=0` and `dev_be_o=4'hF`.
  - With no winner, all `dev_*` are 0.
- **Response tracking:** registers `rsp_vld_q`, `rsp_host_q` (instr/data) and `rsp_dev_q` (mem/dbg/none), loaded on every grant. `rsp_vld_q` is cleared on a cycle with no grant.
- **Response:**
  - When `rsp_vld_q` is set, the host named in `rsp_host_q` gets `rvalid=1`.
  - `rdata` comes from the device named in `rsp_dev_q`.
  - For `none`: `rdata=0` and `err=1`.
  - The non-selected host sees `rvalid=0`, `rdata=0`, `err=0`.
- **Writes:** writes also return `rvalid` (Ibex requires it for data writes). Data comes from the device; `err` applies likewise.
- **Stray responses:** device `rvalid` that disagrees with `rsp_dev_q` is ignored for routing and flagged by a simulation assertion.

## Timing
- Grant latency: 0 cycles, combinational from `req`.
- Response latency: exactly 1 cycle after grant. Devices respond one cycle after their `req`.
- Throughput: one grant per cycle. A new grant in the cycle a response returns is legal (back-to-back).
- Reset values:
  - Outputs derived from the tracking registers (`*_rvalid_o`, `*_err_o`, `*_rdata_o`) are 0.
  - `*_gnt_o`, `mem_req_o`, `dbg_req_o` are 0 while the requests are low.
  - `rsp_vld_q=0`.
- Reset asserted mid-transaction: the pending response is dropped. No `rvalid` appears after release.
- Simultaneous requests: exactly one grant per cycle. Never both grants high.
- A request dropped before grant is legal and leaves no state.

## Configuration
- `CORE_BUS_ARB_RR_EN`:
  - Defined: round-robin arbitration. A `last_q` register (reset: data) records the last granted host; on contention the other host wins. A single requester always wins.
  - Undefined: fixed instruction priority, and no `last_q` register.

## Structure
- Package `core_bus_arb_pkg` holds:
  - `typedef enum logic [1:0] {DevMem, DevDbg, DevNone} dev_sel_e`
  - `typedef enum logic {HostInstr, HostData} host_sel_e`
  - default base/mask constants.
- Sub-module `core_bus_decode` (combinational): address in, `dev_sel_e` out. Instantiated once on the winner's address.

## Test plan
- Instruction read at 0x0000_0080 with SRAM returning 0xDEAD_BEEF → `instr_gnt_o=1` in cycle 0, `mem_req_o=1`; cycle 1 `instr_rvalid_o=1`, `instr_rdata_o=0xDEAD_BEEF`, `instr_err_o=0`.
- Data write to 0x1000_0100, wdata 0x1234_5678, be 4'b0011 → `dbg_req_o=1`, `dev_we_o=1`, `dev_be_o=4'b0011`; cycle 1 `data_rvalid_o=1`, `data_err_o=0`.
- Data read at 0x2000_0000 → `data_gnt_o=1` with no device req; cycle 1 `data_rvalid_o=1`, `data_err_o=1`, `data_rdata_o=0`.
- Both hosts request continuously to SRAM for 4 cycles:
  - Macro undefined: grants instr ×4, data never.
  - `CORE_BUS_ARB_RR_EN` defined: grants alternate instr, data, instr, data, and responses are routed to matching hosts.
- Grant in cycle 0, `rst_ni` pulsed low in cycle 1 → no `rvalid` on either host after release. All outputs are 0 during reset.
- Back-to-back instr, data, instr grants over 3 cycles → rvalid on cycles 1, 2, 3 on the correct hosts with the correct data, and never both rvalids high.
